pong_pos_slew_pio: RTL
======================

# pong_pos_slew_pio

Avalon-MM slave PIO driving CHANNELS paddle/ball position outputs of WIDTH bits each. Software writes a target per channel; the block steps each output toward its target by a programmable STEP every prescaler tick, clamps to [MIN_POS, MAX_POS], and flags arrival through a sticky status and a maskable level interrupt. It sits on the HPS-to-FPGA lightweight bus in the QSYS system and feeds the VGA pong renderer directly, replacing per-axis single-register output PIOs.

## Interface
- CHANNELS, 2: number of position channels, 1..8
- WIDTH, 16: bits per position, 1..32
- MIN_POS, 0: lower clamp, applied to all channels
- MAX_POS, 479: upper clamp, MIN_POS <= MAX_POS < 2**WIDTH
- DIV_W, 20: prescaler width
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- address  in  5  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read data for the current address
- out_port  out  CHANNELS*WIDTH  channel k position at [k*WIDTH +: WIDTH]
- irq  out  1  level interrupt, |(arrived & irq_mask)

## Operation
- Write strobe: chipselect && !write_n. No wait states; readdata is valid in the same cycle for any address.
- Address map (k < CHANNELS; other channel slots and unused addresses read 0, ignore writes):
  - 0..7 TARGET[k] RW: stored as clamp(writedata[WIDTH-1:0]). Reset MIN_POS.
  - 8..15 POS[k] RW: read current position; write = jump, sets POS[k] and TARGET[k] to the clamped value. Jump sets no arrival.
  - 16 CTRL RW: bit0 EN, reset 1. EN=0 freezes all positions and holds the prescaler at 0.
  - 17 DIV RW: DIV_W bits, tick period minus one, reset 0 (tick every cycle).
  - 18 STEP RW: WIDTH bits, reset 1; STEP=0 behaves as 1.
  - 19 STATUS: bits[CHANNELS-1:0] arrived, sticky, write-1-to-clear; bits[8+CHANNELS-1:8] busy (POS!=TARGET), read-only.
  - 20 IRQ_MASK RW: bits[CHANNELS-1:0], reset 0.
- Prescaler: when EN=1, cnt counts 0..DIV; tick asserts for the cycle cnt==DIV, and cnt returns to 0 on the next edge. A write to DIV or to CTRL resets cnt to 0.
- On a tick edge, each channel with POS!=TARGET: if |TARGET-POS| <= STEP, POS<=TARGET and arrived[k]<=1; otherwise POS moves STEP toward TARGET. Compute the difference in WIDTH+1 bits. No wrap is possible because both operands are within the clamp range.
- Channels with POS==TARGET are untouched on a tick. Writing TARGET equal to POS produces no arrival.

## Timing
- Reset: out_port = MIN_POS on every channel, irq=0, arrived=0, cnt=0, and all registers at the reset values listed above.
- Register writes take effect at the strobe edge. The first possible motion is on the next tick after that edge.
- POS update is visible on out_port in the cycle after the tick cycle. irq is derived from registers and asserts in the same cycle arrived becomes 1.
- Simultaneous events:
  - TARGET write in a tick cycle: the tick uses the old target; the new target applies from the next tick.
  - POS jump in a tick cycle: the jump wins for that channel.
  - STATUS W1C in the same cycle as an arrival set for that bit: the set wins.
  - CTRL EN 1->0 in a tick cycle: that tick is still applied.
- Reset asserted mid-motion: all state returns to reset values immediately (asynchronous). No partial step is retained.

## Test plan
- Reset defaults: after reset, out_port={16'd0,16'd0}, readdata at 16 = 1, 18 = 1, 19 = 0, irq=0.
- Slew and arrival: DIV=0, STEP=10, TARGET[0]=25 -> POS[0] reads 10, 20, 25 on consecutive cycles after the write; arrived[0]=1 on the 3rd tick; busy[0] reads 0 afterwards.
- Clamp and jump: write TARGET[1]=600 -> reads back 479. Write POS[1]=1000 -> out_port[31:16]=479 next cycle with no arrival bit. Write POS[0]=5 with writedata=32'hFFFF0005 -> reads back 5.
- Prescaler: DIV=3, STEP=1, TARGET[0]=2 from POS 0 -> POS changes only every 4th cycle, reaching 2 after 8 cycles. EN=0 mid-move -> POS holds; EN=1 -> motion resumes after a full 4-cycle period.
- IRQ path: IRQ_MASK=1, complete a move -> irq=1. Write STATUS=1 -> irq=0 next cycle. Issue the W1C on the same edge as an arrival -> arrived stays 1.
- Collisions: a TARGET write coincident with a tick follows the old target for that step; a POS jump coincident with a tick yields the jump value. Assert reset_n low mid-move -> out_port=0 asynchronously.

Source files
------------

// File: rtl/pong_pos_slew_pio.sv
// pong_pos_slew_pio: Avalon-MM PIO slewing CHANNELS position outputs toward
// software targets. Ports: Avalon slave (address/chipselect/write_n/
// writedata/readdata), out_port (packed positions), irq (level).
module pong_pos_slew_pio #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int MIN_POS  = 0,
  parameter int MAX_POS  = 479,
  parameter int DIV_W    = 20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_POS);

  logic [WIDTH-1:0]    tgt_q [CHANNELS];
  logic [WIDTH-1:0]    tgt_d [CHANNELS];
  logic [WIDTH-1:0]    pos_q [CHANNELS];
  logic [WIDTH-1:0]    pos_d [CHANNELS];
  logic                en_q, en_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    step_q, step_d;
  logic [CHANNELS-1:0] arr_q, arr_d;
  logic [CHANNELS-1:0] mask_q, mask_d;

  logic                wr;
  logic                tick;
  logic [WIDTH-1:0]    stp;
  logic [CHANNELS-1:0] arr_set;
  logic [CHANNELS-1:0] arr_clr;
  logic [CHANNELS-1:0] busy;
  logic                unused_wd;

  assign unused_wd = ^writedata;

  // <= keeps the compare meaningful even when a bound is 0 or all-ones
  function automatic logic [WIDTH-1:0] clamp(
    input logic [WIDTH-1:0] v
  );
    if (v <= MIN_V) return MIN_V;
    if (v >= MAX_V) return MAX_V;
    return v;
  endfunction

  function automatic logic [WIDTH:0] diff_of(
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] t
  );
    return {1'b0, t} - {1'b0, p};
  endfunction

  function automatic logic [WIDTH:0] mag_of(
    input logic [WIDTH:0] d
  );
    return d[WIDTH] ? (~d + 1'b1) : d;
  endfunction

  function automatic logic [WIDTH-1:0] slew(
    input logic [WIDTH-1:0] p,
    input logic [WIDTH-1:0] t,
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH:0] d;
    d = diff_of(p, t);
    if (mag_of(d) <= {1'b0, s}) return t;
    return d[WIDTH] ? p - s : p + s;
  endfunction

  assign wr   = chipselect & ~write_n;
  assign tick = en_q && (cnt_q == div_q);
  assign stp  = (step_q == '0) ? WIDTH'(1) : step_q;
  assign irq  = |(arr_q & mask_q);

  always_comb begin
    tgt_d   = tgt_q;
    pos_d   = pos_q;
    en_d    = en_q;
    div_d   = div_q;
    step_d  = step_q;
    mask_d  = mask_q;
    arr_set = '0;
    arr_clr = '0;
    busy    = '0;
    cnt_d   = (!en_q || tick) ? '0 : cnt_q + 1'b1;

    for (int k = 0; k < CHANNELS; k++) begin
      busy[k] = pos_q[k] != tgt_q[k];
      // tick always uses the target held before this edge
      if (tick && busy[k]) begin
        pos_d[k] = slew(pos_q[k], tgt_q[k], stp);
        arr_set[k] =
          mag_of(diff_of(pos_q[k], tgt_q[k])) <= {1'b0, stp};
      end
      if (wr && address == 5'(k))
        tgt_d[k] = clamp(writedata[WIDTH-1:0]);
      if (wr && address == 5'(8 + k)) begin
        pos_d[k] = clamp(writedata[WIDTH-1:0]);
        tgt_d[k] = clamp(writedata[WIDTH-1:0]);
      end
    end

    if (wr) begin
      unique case (address)
        5'd16: begin
          en_d  = writedata[0];
          cnt_d = '0;
        end
        5'd17: begin
          div_d = writedata[DIV_W-1:0];
          cnt_d = '0;
        end
        5'd18: step_d  = writedata[WIDTH-1:0];
        5'd19: arr_clr = writedata[CHANNELS-1:0];
        5'd20: mask_d  = writedata[CHANNELS-1:0];
        default: ;
      endcase
    end

    // a set in the same cycle beats the clear
    arr_d = (arr_q & ~arr_clr) | arr_set;
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (address == 5'(k))
        readdata = 32'(tgt_q[k]);
      if (address == 5'(8 + k))
        readdata = 32'(pos_q[k]);
    end
    unique case (address)
      5'd16: readdata[0] = en_q;
      5'd17: readdata = 32'(div_q);
      5'd18: readdata = 32'(step_q);
      5'd19: begin
        readdata[CHANNELS-1:0]  = arr_q;
        readdata[8 +: CHANNELS] = busy;
      end
      5'd20: readdata[CHANNELS-1:0] = mask_q;
      default: ;
    endcase
  end

  always_comb begin
    out_port = '0;
    for (int k = 0; k < CHANNELS; k++)
      out_port[k*WIDTH +: WIDTH] = pos_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        tgt_q[k] <= MIN_V;
        pos_q[k] <= MIN_V;
      end
      en_q   <= 1'b1;
      div_q  <= '0;
      cnt_q  <= '0;
      step_q <= WIDTH'(1);
      arr_q  <= '0;
      mask_q <= '0;
    end else begin
      tgt_q  <= tgt_d;
      pos_q  <= pos_d;
      en_q   <= en_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      arr_q  <= arr_d;
      mask_q <= mask_d;
    end
  end

endmodule
